mandel_engine_scheduler: RTL and testbench

- Sequences a Mandelbrot frame over NUM_ENGINES parallel depth-calculator engines.
- Walks pixel coordinates in raster order and dispatches each pixel round-robin to an idle engine.
- Captures each engine's single-cycle done result and retires depths in strict raster order to the colour LUT/packer stage, with SOF/EOL markers.
- Sits between the coordinate mapper/engines and the packer, replacing the single-engine x/y counter.

---
 rtl/mandel_sched_pkg.sv | 24 ++
 rtl/mandel_result_slot.sv | 89 ++++++++
 rtl/mandel_engine_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_mandel_engine_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_sched_pkg.sv
// ---------------------------------------------------------------------------
// mandel_sched_pkg
// Shared definitions for the Mandelbrot multi-engine scheduler:
//   - sched_state_t : frame sequencer states (IDLE, RUN, DRAIN)
//   - X_W / Y_W     : fixed pixel coordinate widths
//   - ptr_inc()     : round-robin pointer increment with wrap at NUM_ENGINES
// ---------------------------------------------------------------------------
package mandel_sched_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Next round-robin slot index; wraps to 0 after num-1.
    function automatic int ptr_inc(input int ptr, input int num);
        return (ptr + 1 >= num) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mandel_result_slot.sv
// ---------------------------------------------------------------------------
// mandel_result_slot
// Tracks one depth engine: its busy flag, the raster tags (sof/eol/last)
// captured when a pixel is dispatched to it, and the depth result captured
// from its done pulse, held until the retire stage takes it.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start             pixel dispatched to this engine this cycle
//   i_sof/i_eol/i_last  raster tags of the dispatched pixel
//   i_done, i_depth     single-cycle engine result
//   i_retire            slot consumed by the output stage this cycle
//   o_busy              engine is computing
//   o_valid             result held, waiting to retire
//   o_depth/o_sof/o_eol/o_last  held result and tags
//   o_err               done pulse arrived while the engine was not busy
// ---------------------------------------------------------------------------
module mandel_result_slot
    import mandel_sched_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_sof,
    input  logic               i_eol,
    input  logic               i_last,
    input  logic               i_done,
    input  logic [DEPTH_W-1:0] i_depth,
    input  logic               i_retire,
    output logic               o_busy,
    output logic               o_valid,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_sof,
    output logic               o_eol,
    output logic               o_last,
    output logic               o_err
);

    logic               r_busy;
    logic               r_valid;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_sof;
    logic               r_eol;
    logic               r_last;
    logic               w_capture;

    // A done is only meaningful while the engine owns a pixel.
    assign w_capture = i_done & r_busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_depth <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            // Tags are written only on dispatch, which requires the slot to be
            // empty, so a result waiting to retire never sees its tags change.
            if (i_start) begin
                r_busy <= 1'b1;
                r_sof  <= i_sof;
                r_eol  <= i_eol;
                r_last <= i_last;
            end else if (i_done) begin
                r_busy <= 1'b0;
            end

            if (w_capture) begin
                r_valid <= 1'b1;
                r_depth <= i_depth;
            end else if (i_retire) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_depth = r_depth;
    assign o_sof   = r_sof;
    assign o_eol   = r_eol;
    assign o_last  = r_last;
    assign o_err   = i_done & ~r_busy;

endmodule

// File: rtl/mandel_engine_scheduler.sv
// ---------------------------------------------------------------------------
// mandel_engine_scheduler
// Walks a frame's pixels in raster order, hands each pixel round-robin to one
// of NUM_ENGINES depth engines, captures their done results out of order and
// retires depths to the packer strictly in raster order with SOF/EOL markers.
//
// Ports:
//   out_stream_aclk     clock
//   periph_resetn       synchronous active-low reset (also resets engines)
//   run                 1 = produce frames continuously, 0 = stop at frame end
//   eng_start           one-hot start pulse, eng_x/eng_y valid with it
//   eng_done/eng_depth  per-engine done pulse and depth (engine i at
//                       bits [i*DEPTH_W +: DEPTH_W])
//   pix_valid/pix_ready handshake of retired pixels
//   pix_depth/pix_sof/pix_eol  retired pixel data and markers
//   frame_done          one-cycle pulse after the last pixel of a frame retires
//   frame_count         completed frames, wraps
//   busy                sequencer not idle
//   err_sticky          done seen from an idle engine; cleared by reset only
//
// Optional build macro MANDEL_SCHED_PERF_EN adds perf_frame_cycles and
// perf_stall_cycles (both latched when a frame's last pixel retires).
// ---------------------------------------------------------------------------
module mandel_engine_scheduler
    import mandel_sched_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int DEPTH_W     = 10
) (
    input  logic                           out_stream_aclk,
    input  logic                           periph_resetn,
    input  logic                           run,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [X_W-1:0]                 eng_x,
    output logic [Y_W-1:0]                 eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [DEPTH_W-1:0]             pix_depth,
    output logic                           pix_sof,
    output logic                           pix_eol,
    output logic                           frame_done,
    output logic [15:0]                    frame_count,
    output logic                           busy,
    output logic                           err_sticky
`ifdef MANDEL_SCHED_PERF_EN
    ,
    output logic [31:0]                    perf_frame_cycles,
    output logic [31:0]                    perf_stall_cycles
`endif
);

    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

    generate
        if (X_SIZE < 1 || X_SIZE > 1024 || Y_SIZE < 1 || Y_SIZE > 512) begin : g_bad_size
            $error("mandel_engine_scheduler: X_SIZE must be 1..1024 and Y_SIZE 1..512");
        end
        if (NUM_ENGINES < 1 || NUM_ENGINES > 16 ||
            (NUM_ENGINES & (NUM_ENGINES - 1)) != 0) begin : g_bad_engines
            $error("mandel_engine_scheduler: NUM_ENGINES must be a power of two in 1..16");
        end
    endgenerate

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [X_W-1:0]   r_x;
    logic [X_W-1:0]   w_x_nxt;
    logic [Y_W-1:0]   r_y;
    logic [Y_W-1:0]   w_y_nxt;
    logic [PTR_W-1:0] r_dptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_frame_done;
    logic [15:0]      r_frame_count;
    logic             r_err_sticky;

    logic [NUM_ENGINES-1:0] w_start;
    logic [NUM_ENGINES-1:0] w_retire_vec;
    logic [NUM_ENGINES-1:0] w_busy;
    logic [NUM_ENGINES-1:0] w_valid;
    logic [NUM_ENGINES-1:0] w_sof;
    logic [NUM_ENGINES-1:0] w_eol;
    logic [NUM_ENGINES-1:0] w_last;
    logic [NUM_ENGINES-1:0] w_err;
    logic [DEPTH_W-1:0]     w_slot_depth [NUM_ENGINES];

    logic               w_slot_free;
    logic               w_dispatch;
    logic               w_pix_valid;
    logic [DEPTH_W-1:0] w_pix_depth;
    logic               w_pix_sof;
    logic               w_pix_eol;
    logic               w_pix_last;
    logic               w_retire;
    logic               w_last_retire;
    logic               w_tag_sof;
    logic               w_tag_eol;
    logic               w_tag_last;

    // Raster tags of the pixel currently offered for dispatch.
    assign w_tag_sof  = (r_x == '0) && (r_y == '0);
    assign w_tag_eol  = (r_x == X_LAST);
    assign w_tag_last = (r_x == X_LAST) && (r_y == Y_LAST);

    // Dispatch needs the pointed-to engine idle AND its previous result
    // retired, which keeps slot ownership in strict raster order.
    always_comb begin
        w_slot_free = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (r_dptr == PTR_W'(i)) begin
                w_slot_free = ~w_busy[i] & ~w_valid[i];
            end
        end
    end

    assign w_dispatch = (r_state == ST_RUN) && w_slot_free;

    always_comb begin
        w_start = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            w_start[i] = w_dispatch && (r_dptr == PTR_W'(i));
        end
    end

    // Retire stage: only the slot at the read pointer may leave.
    always_comb begin
        w_pix_valid = 1'b0;
        w_pix_depth = '0;
        w_pix_sof   = 1'b0;
        w_pix_eol   = 1'b0;
        w_pix_last  = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (r_rptr == PTR_W'(i)) begin
                w_pix_valid = w_valid[i];
                w_pix_depth = w_slot_depth[i];
                w_pix_sof   = w_sof[i];
                w_pix_eol   = w_eol[i];
                w_pix_last  = w_last[i];
            end
        end
    end

    assign w_retire      = w_pix_valid & pix_ready;
    assign w_last_retire = w_retire & w_pix_last;

    always_comb begin
        w_retire_vec = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            w_retire_vec[i] = w_retire && (r_rptr == PTR_W'(i));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_slot
            mandel_result_slot #(
                .DEPTH_W (DEPTH_W)
            ) u_slot (
                .i_clk    (out_stream_aclk),
                .i_rst_n  (periph_resetn),
                .i_start  (w_start[gi]),
                .i_sof    (w_tag_sof),
                .i_eol    (w_tag_eol),
                .i_last   (w_tag_last),
                .i_done   (eng_done[gi]),
                .i_depth  (eng_depth[gi*DEPTH_W +: DEPTH_W]),
                .i_retire (w_retire_vec[gi]),
                .o_busy   (w_busy[gi]),
                .o_valid  (w_valid[gi]),
                .o_depth  (w_slot_depth[gi]),
                .o_sof    (w_sof[gi]),
                .o_eol    (w_eol[gi]),
                .o_last   (w_last[gi]),
                .o_err    (w_err[gi])
            );
        end
    endgenerate

    // Frame sequencer next state and raster coordinate advance.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end
            ST_RUN: begin
                if (w_dispatch) begin
                    if (r_x == X_LAST) begin
                        w_x_nxt = '0;
                        if (r_y == Y_LAST) begin
                            w_y_nxt     = '0;
                            w_state_nxt = ST_DRAIN;
                        end else begin
                            w_y_nxt = r_y + Y_W'(1);
                        end
                    end else begin
                        w_x_nxt = r_x + X_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // run is only looked at here, at the frame boundary.
                if (w_last_retire) begin
                    w_state_nxt = run ? ST_RUN : ST_IDLE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            r_dptr        <= '0;
            r_rptr        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_sticky  <= 1'b0;
        end else begin
            if (w_dispatch) begin
                r_dptr <= PTR_W'(ptr_inc(int'(r_dptr), NUM_ENGINES));
            end
            if (w_retire) begin
                r_rptr <= PTR_W'(ptr_inc(int'(r_rptr), NUM_ENGINES));
            end
            r_frame_done <= w_last_retire;
            if (w_last_retire) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (|w_err) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

`ifdef MANDEL_SCHED_PERF_EN
    logic        w_first_dispatch;
    logic        r_perf_active;
    logic [31:0] r_perf_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_perf_frame;
    logic [31:0] r_perf_stall;

    assign w_first_dispatch = w_dispatch & w_tag_sof;

    // Frame cycles span the first dispatch cycle through the final retire
    // cycle inclusive; both values appear together with frame_done.
    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            r_perf_active <= 1'b0;
            r_perf_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_perf_frame  <= '0;
            r_perf_stall  <= '0;
        end else if (w_last_retire) begin
            r_perf_frame  <= r_perf_cnt + 32'd1;
            r_perf_stall  <= r_stall_cnt;
            r_perf_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_perf_active <= 1'b0;
        end else begin
            if (w_first_dispatch) begin
                r_perf_active <= 1'b1;
                r_perf_cnt    <= 32'd1;
            end else if (r_perf_active) begin
                r_perf_cnt <= r_perf_cnt + 32'd1;
            end
            if (w_pix_valid && !pix_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_frame_cycles = r_perf_frame;
    assign perf_stall_cycles = r_perf_stall;
`endif

    assign eng_start   = w_start;
    assign eng_x       = r_x;
    assign eng_y       = r_y;
    assign pix_valid   = w_pix_valid;
    assign pix_depth   = w_pix_depth;
    assign pix_sof     = w_pix_sof;
    assign pix_eol     = w_pix_eol;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign busy        = (r_state != ST_IDLE);
    assign err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mandel_engine_scheduler
// Directed bench for a 4x2 frame over 4 engines. A behavioural engine model
// answers each start after a per-engine latency with depth = y*16 + x + 1.
// ---------------------------------------------------------------------------
module tb_mandel_engine_scheduler;

    localparam int N  = 4;
    localparam int XS = 4;
    localparam int YS = 2;
    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            resetn;
    logic            run;
    logic [N-1:0]    eng_start;
    logic [9:0]      eng_x;
    logic [8:0]      eng_y;
    logic [N-1:0]    eng_done;
    logic [N*DW-1:0] eng_depth;
    logic            pix_valid;
    logic            pix_ready;
    logic [DW-1:0]   pix_depth;
    logic            pix_sof;
    logic            pix_eol;
    logic            frame_done;
    logic [15:0]     frame_count;
    logic            busy;
    logic            err_sticky;
`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0]     perf_frame_cycles;
    logic [31:0]     perf_stall_cycles;
`endif

    mandel_engine_scheduler #(
        .NUM_ENGINES (N),
        .X_SIZE      (XS),
        .Y_SIZE      (YS),
        .DEPTH_W     (DW)
    ) dut (
        .out_stream_aclk   (clk),
        .periph_resetn     (resetn),
        .run               (run),
        .eng_start         (eng_start),
        .eng_x             (eng_x),
        .eng_y             (eng_y),
        .eng_done          (eng_done),
        .eng_depth         (eng_depth),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_depth         (pix_depth),
        .pix_sof           (pix_sof),
        .pix_eol           (pix_eol),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .busy              (busy),
        .err_sticky        (err_sticky)
`ifdef MANDEL_SCHED_PERF_EN
        ,
        .perf_frame_cycles (perf_frame_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] dep(input int x, input int y);
        return 10'(y * 16 + x + 1);
    endfunction

    // Engine model
    int           lat [N];
    logic [N-1:0] spur_mask = '0;
    int           first_done [N];

    initial begin
        int cnt [N];
        int ex  [N];
        int ey  [N];
        eng_done  = '0;
        eng_depth = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; ex[i] = 0; ey[i] = 0; first_done[i] = -1;
        end
        forever begin
            @(negedge clk);
            eng_done = spur_mask;
            if (!resetn) begin
                eng_done = '0;
                for (int i = 0; i < N; i++) begin
                    cnt[i] = 0; first_done[i] = -1;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (cnt[i] != 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            eng_done[i] = 1'b1;
                            eng_depth[i*DW +: DW] = dep(ex[i], ey[i]);
                            if (first_done[i] < 0) first_done[i] = cyc;
                        end
                    end
                    if (eng_start[i]) begin
                        cnt[i] = lat[i];
                        ex[i]  = int'(eng_x);
                        ey[i]  = int'(eng_y);
                    end
                end
            end
        end
    end

    // Monitor: dispatches, retires, frame_done pulses
    typedef struct { int eng; int x; int y; } disp_t;
    typedef struct { logic [DW-1:0] depth; logic sof; logic eol; } ret_t;
    disp_t disp_q [$];
    ret_t  ret_q  [$];
    int    fd_cnt = 0;
    int    first_valid_cyc = -1;

    initial begin
        disp_t d;
        ret_t  r;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                disp_q.delete();
                ret_q.delete();
                fd_cnt = 0;
                first_valid_cyc = -1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (eng_start[i]) begin
                        d.eng = i; d.x = int'(eng_x); d.y = int'(eng_y);
                        disp_q.push_back(d);
                    end
                end
                if (pix_valid && pix_ready) begin
                    r.depth = pix_depth; r.sof = pix_sof; r.eol = pix_eol;
                    ret_q.push_back(r);
                end
                if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (frame_done) fd_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        run       = 1'b0;
        pix_ready = 1'b1;
        spur_mask = '0;
        step(3);
        resetn = 1'b1;
    endtask

    task automatic wait_disp(input int n, input int budget, input string tag);
        int k = 0;
        while (disp_q.size() < n && k < budget) begin step(1); k++; end
        if (disp_q.size() < n) check_eq(tag, 0, 1);
    endtask

    task automatic wait_ret(input int n, input int budget, input string tag);
        int k = 0;
        while (ret_q.size() < n && k < budget) begin step(1); k++; end
        if (ret_q.size() < n) check_eq(tag, 0, 1);
    endtask

    task automatic wait_fd(input int n, input int budget, input string tag);
        int k = 0;
        while (fd_cnt < n && k < budget) begin step(1); k++; end
        if (fd_cnt < n) check_eq(tag, 0, 1);
    endtask

    // Checks all XS*YS retired pixels against the raster-order model.
    task automatic check_frame(input string pfx);
        check_eq({pfx, "_ret_count"}, ret_q.size(), XS * YS);
        if (ret_q.size() == XS * YS) begin
            for (int k = 0; k < XS * YS; k++) begin
                check_eq($sformatf("%s_px%0d_depth", pfx, k), ret_q[k].depth, dep(k % XS, k / XS));
                check_eq($sformatf("%s_px%0d_sof", pfx, k), ret_q[k].sof, (k == 0));
                check_eq($sformatf("%s_px%0d_eol", pfx, k), ret_q[k].eol, (k % XS == XS - 1));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] s_depth;
        logic          s_sof;
        logic          s_eol;
        logic          held_ok;
        int            disp_at_stall;
        int            k;

        for (int i = 0; i < N; i++) lat[i] = 5;

        // ---- Reset state ----
        do_reset();
        check_eq("rst_pix_valid",   pix_valid,   0);
        check_eq("rst_eng_start",   eng_start,   0);
        check_eq("rst_busy",        busy,        0);
        check_eq("rst_frame_count", frame_count, 0);
        check_eq("rst_err_sticky",  err_sticky,  0);
        check_eq("rst_frame_done",  frame_done,  0);
        check_eq("rst_pix_depth",   pix_depth,   0);

        // ---- Full frame, run dropped during the third pixel ----
        run = 1'b1;
        wait_disp(3, 50, "t1_disp3_timeout");
        run = 1'b0;
        wait_fd(1, 400, "t1_fd_timeout");
        step(20);
        check_frame("t1");
        check_eq("t1_disp_count", disp_q.size(), XS * YS);
        if (disp_q.size() == XS * YS) begin
            for (int j = 0; j < XS * YS; j++) begin
                check_eq($sformatf("t1_d%0d_eng", j), disp_q[j].eng, j % N);
                check_eq($sformatf("t1_d%0d_x", j),   disp_q[j].x,   j % XS);
                check_eq($sformatf("t1_d%0d_y", j),   disp_q[j].y,   j / XS);
            end
        end
        check_eq("t1_frame_done_pulses", fd_cnt,      1);
        check_eq("t1_frame_count",       frame_count, 1);
        check_eq("t1_busy_idle",         busy,        0);
        check_eq("t1_err_sticky",        err_sticky,  0);

        // ---- Out-of-order completion ----
        lat[0] = 12; lat[1] = 5; lat[2] = 3; lat[3] = 5;
        do_reset();
        run = 1'b1;
        wait_disp(1, 50, "t2_disp_timeout");
        run = 1'b0;
        wait_fd(1, 400, "t2_fd_timeout");
        step(5);
        check_eq("t2_e2_before_e0", (first_done[2] >= 0) && (first_done[2] < first_done[0]), 1);
        check_eq("t2_first_valid_cyc", first_valid_cyc, first_done[0] + 1);
        check_frame("t2");
        check_eq("t2_frame_count", frame_count, 1);

        // ---- Downstream stall of 20 cycles mid-frame ----
        for (int i = 0; i < N; i++) lat[i] = 5;
        do_reset();
        run = 1'b1;
        wait_disp(1, 50, "t3_disp_timeout");
        run = 1'b0;
        wait_ret(2, 100, "t3_ret2_timeout");
        pix_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!pix_valid && k < 50) begin @(negedge clk); k++; end
        check_eq("t3_valid_in_stall", pix_valid, 1);
        s_depth = pix_depth; s_sof = pix_sof; s_eol = pix_eol;
        held_ok = 1'b1;
        for (int j = 1; j < 20; j++) begin
            @(negedge clk);
            if (pix_valid !== 1'b1 || pix_depth !== s_depth || pix_sof !== s_sof || pix_eol !== s_eol)
                held_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        disp_at_stall = disp_q.size();
        pix_ready = 1'b1;
        check_eq("t3_held_stable",   held_ok,       1);
        check_eq("t3_stall_depth",   s_depth,       dep(2, 0));
        check_eq("t3_stall_sof",     s_sof,         0);
        check_eq("t3_disp_at_stall", disp_at_stall, 6);
        wait_fd(1, 400, "t3_fd_timeout");
        step(5);
        check_frame("t3");
        check_eq("t3_frame_done_pulses", fd_cnt,      1);
        check_eq("t3_frame_count",       frame_count, 1);
`ifdef MANDEL_SCHED_PERF_EN
        check_eq("t3_perf_stall",     perf_stall_cycles,      20);
        check_eq("t3_perf_frame_nz",  perf_frame_cycles > 0,  1);
`endif

        // ---- Spurious done, then reset mid-frame ----
        do_reset();
        step(2);
        spur_mask = 4'b0010;
        step(1);
        spur_mask = '0;
        step(2);
        check_eq("t5_err_sticky",   err_sticky,    1);
        check_eq("t5_no_retire",    ret_q.size(),  0);
        check_eq("t5_pix_valid",    pix_valid,     0);
        check_eq("t5_busy",         busy,          0);
        run = 1'b1;
        wait_fd(1, 400, "t5_fd_timeout");
        step(3);
        check_eq("t5_fc_before",    frame_count,   1);
        check_eq("t5_busy_before",  busy,          1);
        resetn = 1'b0;
        step(1);
        check_eq("t5_rst_eng_start",   eng_start,   0);
        check_eq("t5_rst_eng_x",       eng_x,       0);
        check_eq("t5_rst_pix_valid",   pix_valid,   0);
        check_eq("t5_rst_pix_depth",   pix_depth,   0);
        check_eq("t5_rst_pix_sof",     pix_sof,     0);
        check_eq("t5_rst_pix_eol",     pix_eol,     0);
        check_eq("t5_rst_frame_done",  frame_done,  0);
        check_eq("t5_rst_frame_count", frame_count, 0);
        check_eq("t5_rst_busy",        busy,        0);
        check_eq("t5_rst_err_sticky",  err_sticky,  0);
        run    = 1'b0;
        resetn = 1'b1;
        step(10);
        check_eq("t5_idle_no_start", disp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
